// File: rtl/rom_download_ctrl.sv
// ROM download controller: steers host ioctl writes for one index into a ROM port
// and holds the game core in reset until a download has settled. Optional ROM_CHECKSUM_EN adds rom_sum.
module rom_download_ctrl #(
  parameter logic [7:0] INDEX       = 8'h00,
  parameter int         ROM_AW      = 16,
  parameter int         RST_HOLD    = 16,
  parameter int         WAIT_CYCLES = 0
) (
  input  logic              clk_sys,
  input  logic              RESET,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [7:0]        rom_data,
  output logic              core_reset,
  output logic              rom_loaded,
  output logic [ROM_AW:0]   byte_count,
  output logic              addr_ovf
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [7:0]        rom_sum
`endif
);

  typedef enum logic [1:0] {UNLOADED, LOADING, HOLD, RUN} state_t;

  localparam logic [15:0]     HOLD_LAST = 16'(RST_HOLD - 1);
  localparam logic [7:0]      WAIT_LD   = 8'(WAIT_CYCLES);
  localparam logic [ROM_AW:0] BYTE_MAX  = {1'b1, {ROM_AW{1'b0}}};
  localparam logic [ROM_AW:0] BYTE_ONE  = (ROM_AW+1)'(1);

  state_t            state_q      = UNLOADED;
  state_t            state_d;
  logic [15:0]       hold_cnt_q   = '0;
  logic [15:0]       hold_cnt_d;
  logic [7:0]        wait_cnt_q   = '0;
  logic [7:0]        wait_cnt_d;
  logic              rom_we_q     = 1'b0;
  logic              rom_we_d;
  logic [ROM_AW-1:0] rom_addr_q   = '0;
  logic [ROM_AW-1:0] rom_addr_d;
  logic [7:0]        rom_data_q   = '0;
  logic [7:0]        rom_data_d;
  logic              core_reset_q = 1'b1;
  logic              core_reset_d;
  logic              rom_loaded_q = 1'b0;
  logic              rom_loaded_d;
  logic [ROM_AW:0]   byte_count_q = '0;
  logic [ROM_AW:0]   byte_count_d;
  logic              addr_ovf_q   = 1'b0;
  logic              addr_ovf_d;
`ifdef ROM_CHECKSUM_EN
  logic [7:0]        rom_sum_q    = '0;
  logic [7:0]        rom_sum_d;
`endif

  logic sel;
  logic in_range;
  logic wr_ok;
  logic accept;
  logic ovf_hit;
  logic load_entry;

  always_comb begin
    sel      = ioctl_download && (ioctl_index == INDEX);
    in_range = (ioctl_addr >> ROM_AW) == 25'd0;
    wr_ok    = ioctl_wr && sel && !ioctl_wait && !RESET;
    accept   = wr_ok && in_range;
    ovf_hit  = wr_ok && !in_range;
  end

  always_comb begin
    state_d      = state_q;
    rom_loaded_d = rom_loaded_q;
    if (RESET) begin
      if (sel)               state_d = LOADING;
      else if (rom_loaded_q) state_d = HOLD;
      else                   state_d = UNLOADED;
    end else begin
      case (state_q)
        UNLOADED: if (sel) state_d = LOADING;
        LOADING: begin
          if (!sel) begin
            state_d      = HOLD;
            rom_loaded_d = 1'b1;
          end
        end
        HOLD: begin
          if (sel)                          state_d = LOADING;
          else if (hold_cnt_q == HOLD_LAST) state_d = RUN;
        end
        RUN:      if (sel) state_d = LOADING;
        default:  state_d = UNLOADED;
      endcase
    end

    // Counter restarts from 0 on every entry to HOLD, including a reset re-entry.
    hold_cnt_d = '0;
    if (state_d == HOLD && state_q == HOLD && !RESET)
      hold_cnt_d = hold_cnt_q + 16'd1;

    core_reset_d = (state_d != RUN);
    load_entry   = (state_d == LOADING) && (state_q != LOADING);
  end

  always_comb begin
    rom_we_d   = accept;
    rom_addr_d = accept ? ioctl_addr[ROM_AW-1:0] : rom_addr_q;
    rom_data_d = accept ? ioctl_dout : rom_data_q;

    byte_count_d = load_entry ? '0 : byte_count_q;
    if (accept && byte_count_d != BYTE_MAX)
      byte_count_d = byte_count_d + BYTE_ONE;

    addr_ovf_d = load_entry ? 1'b0 : addr_ovf_q;
    if (ovf_hit)
      addr_ovf_d = 1'b1;

    wait_cnt_d = wait_cnt_q;
    if (accept)                  wait_cnt_d = WAIT_LD;
    else if (wait_cnt_q != 8'd0) wait_cnt_d = wait_cnt_q - 8'd1;
  end

`ifdef ROM_CHECKSUM_EN
  always_comb begin
    rom_sum_d = load_entry ? 8'd0 : rom_sum_q;
    if (accept)
      rom_sum_d = rom_sum_d + ioctl_dout;
  end
`endif

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      rom_we_q   <= 1'b0;
      wait_cnt_q <= 8'd0;
    end else begin
      rom_we_q   <= rom_we_d;
      wait_cnt_q <= wait_cnt_d;
    end
    state_q      <= state_d;
    hold_cnt_q   <= hold_cnt_d;
    core_reset_q <= core_reset_d;
    rom_loaded_q <= rom_loaded_d;
    byte_count_q <= byte_count_d;
    addr_ovf_q   <= addr_ovf_d;
    rom_addr_q   <= rom_addr_d;
    rom_data_q   <= rom_data_d;
`ifdef ROM_CHECKSUM_EN
    rom_sum_q    <= rom_sum_d;
`endif
  end

  assign ioctl_wait = (WAIT_CYCLES > 0) && (wait_cnt_q != 8'd0);
  assign rom_we     = rom_we_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign core_reset = core_reset_q;
  assign rom_loaded = rom_loaded_q;
  assign byte_count = byte_count_q;
  assign addr_ovf   = addr_ovf_q;
`ifdef ROM_CHECKSUM_EN
  assign rom_sum    = rom_sum_q;
`endif

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Bench for rom_download_ctrl: directed scenarios plus randomized writes, all checked
// every cycle against a behavioural model of the download/hold/run rules.
module tb_rom_download_ctrl;

  localparam logic [7:0] INDEX       = 8'h00;
  localparam int         ROM_AW      = 16;
  localparam int         RST_HOLD    = 4;
  localparam int         WAIT_CYCLES = 3;

  logic              clk_sys = 1'b0;
  logic              RESET = 1'b0;
  logic              ioctl_download = 1'b0;
  logic [7:0]        ioctl_index = 8'h00;
  logic              ioctl_wr = 1'b0;
  logic [24:0]       ioctl_addr = '0;
  logic [7:0]        ioctl_dout = 8'h00;
  logic              ioctl_wait;
  logic              rom_we;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              core_reset;
  logic              rom_loaded;
  logic [ROM_AW:0]   byte_count;
  logic              addr_ovf;
`ifdef ROM_CHECKSUM_EN
  logic [7:0]        rom_sum;
`endif

  always #5 clk_sys = ~clk_sys;

  rom_download_ctrl #(
    .INDEX(INDEX), .ROM_AW(ROM_AW), .RST_HOLD(RST_HOLD), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk_sys(clk_sys), .RESET(RESET), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .rom_we(rom_we),
    .rom_addr(rom_addr), .rom_data(rom_data), .core_reset(core_reset),
    .rom_loaded(rom_loaded), .byte_count(byte_count), .addr_ovf(addr_ovf)
`ifdef ROM_CHECKSUM_EN
    , .rom_sum(rom_sum)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: phase flags plus a countdown of reset-hold cycles left.
  bit m_unloaded = 1'b1;
  bit m_loading  = 1'b0;
  int m_hold_left = 0;
  bit m_loaded = 1'b0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;
  int m_wait = 0;
  bit m_we = 1'b0;
  int m_addr = 0;
  int m_data = 0;
  int m_sum = 0;
  int we_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_running();
    return !m_unloaded && !m_loading && (m_hold_left == 0);
  endfunction

  task automatic model_step();
    bit sel, was_loading, in_rng, usable, acc;
    sel         = ioctl_download && (ioctl_index == INDEX);
    in_rng      = (ioctl_addr >> ROM_AW) == 0;
    usable      = !RESET && ioctl_wr && sel && (m_wait == 0);
    acc         = usable && in_rng;
    was_loading = m_loading;
    if (RESET) begin
      m_loading   = sel;
      m_unloaded  = !sel && !m_loaded;
      m_hold_left = (!sel && m_loaded) ? RST_HOLD : 0;
    end else if (m_unloaded) begin
      if (sel) begin m_unloaded = 1'b0; m_loading = 1'b1; end
    end else if (m_loading) begin
      if (!sel) begin m_loading = 1'b0; m_loaded = 1'b1; m_hold_left = RST_HOLD; end
    end else if (sel) begin
      m_loading = 1'b1; m_hold_left = 0;
    end else if (m_hold_left > 0) begin
      m_hold_left--;
    end
    if (m_loading && !was_loading) begin
      m_cnt = 0; m_ovf = 1'b0; m_sum = 0;
    end
    m_we = acc;
    if (acc) begin
      if (m_cnt < (1 << ROM_AW)) m_cnt++;
      m_sum  = (m_sum + ioctl_dout) % 256;
      m_addr = ioctl_addr % (1 << ROM_AW);
      m_data = ioctl_dout;
    end
    if (usable && !in_rng) m_ovf = 1'b1;
    if (RESET)           m_wait = 0;
    else if (acc)        m_wait = WAIT_CYCLES;
    else if (m_wait > 0) m_wait--;
  endtask

  task automatic compare_all();
    chk("core_reset", core_reset, !m_running());
    chk("rom_loaded", rom_loaded, m_loaded);
    chk("byte_count", byte_count, m_cnt);
    chk("addr_ovf",   addr_ovf,   m_ovf);
    chk("ioctl_wait", ioctl_wait, m_wait != 0);
    chk("rom_we",     rom_we,     m_we);
    chk("rom_addr",   rom_addr,   m_addr);
    chk("rom_data",   rom_data,   m_data);
`ifdef ROM_CHECKSUM_EN
    chk("rom_sum",    rom_sum,    m_sum);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_sys);
    #1;
    if (rom_we === 1'b1) we_pulses++;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pulses0, waits;
    logic [7:0] bytes [3];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;

    // Power-up values before any clock edge
    #1;
    compare_all();
    chk("pwrup_core_reset", core_reset, 1'b1);
    chk("pwrup_rom_addr", rom_addr, 0);

    // Idle 100 cycles with no download
    idle(100);
    chk("idle_we_pulses", we_pulses, 0);
    chk("idle_core_reset", core_reset, 1'b1);
    chk("idle_rom_loaded", rom_loaded, 1'b0);

    // Three-byte download at index 0
    ioctl_download = 1'b1; ioctl_index = INDEX;
    tick();
    for (int i = 0; i < 3; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = bytes[i];
      tick();
      chk("dl_we_latency", rom_we, 1'b1);
      chk("dl_data", rom_data, bytes[i]);
      ioctl_wr = 1'b0;
      idle(4);
    end
    ioctl_download = 1'b0;
    n = 0;
    do begin tick(); n++; end while (core_reset === 1'b1 && n < 50);
    chk("dl_fall_to_run", n, RST_HOLD + 1);
    chk("dl_byte_count", byte_count, 3);
    chk("dl_rom_loaded", rom_loaded, 1'b1);
    chk("dl_we_pulses", we_pulses, 3);
`ifdef ROM_CHECKSUM_EN
    chk("dl_rom_sum", rom_sum, 8'h66);
`endif

    // Writes to another index are ignored and the core keeps running
    pulses0 = we_pulses;
    ioctl_download = 1'b1; ioctl_index = 8'h01;
    for (int i = 0; i < 6; i++) begin
      ioctl_wr = (i % 2 == 0); ioctl_addr = 25'(i); ioctl_dout = 8'($urandom);
      tick();
    end
    ioctl_wr = 1'b0;
    chk("idx1_no_we", we_pulses - pulses0, 0);
    chk("idx1_core_running", core_reset, 1'b0);

    // Reload, then an out-of-range address
    ioctl_index = INDEX;
    tick();
    ioctl_wr = 1'b1; ioctl_addr = 25'h10000; ioctl_dout = 8'h5A;
    tick();
    ioctl_wr = 1'b0;
    chk("ovf_dropped", rom_we, 1'b0);
    chk("ovf_sticky", addr_ovf, 1'b1);
    chk("ovf_count", byte_count, 0);

    // Back-to-back strobes against the wait stretch
    waits = 0;
    for (int i = 0; i < 4; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(16 + i); ioctl_dout = 8'(i + 1);
      tick();
      if (ioctl_wait === 1'b1) waits++;
    end
    ioctl_wr = 1'b0;
    chk("wait_len", waits, WAIT_CYCLES);
    chk("wait_count", byte_count, 1);
    idle(3);

    // Randomized writes inside the download
    for (int i = 0; i < 300; i++) begin
      ioctl_wr   = ($urandom_range(0, 2) == 0);
      ioctl_addr = ($urandom_range(0, 7) == 0) ? 25'($urandom) | 25'h10000
                                               : 25'($urandom_range(0, 16'hFFFF));
      ioctl_dout = 8'($urandom);
      tick();
    end
    ioctl_wr = 1'b0;
    idle(4);

    // Reset with a strobe mid-download: write suppressed, download resumes
    n = byte_count;
    RESET = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 25'h0040; ioctl_dout = 8'hC3;
    tick();
    chk("rst_we_suppressed", rom_we, 1'b0);
    RESET = 1'b0; ioctl_wr = 1'b0;
    tick();
    chk("rst_still_loading", core_reset, 1'b1);
    chk("rst_count_kept", byte_count, n);
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    chk("rst_resume_we", rom_we, 1'b1);
    idle(4);

    // Finish download, reach RUN, then reset the core from RUN
    ioctl_download = 1'b0;
    n = 0;
    do begin tick(); n++; end while (core_reset === 1'b1 && n < 50);
    chk("rerun_reached", core_reset, 1'b0);
    idle(3);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    n = 1;
    do begin tick(); n++; end while (core_reset === 1'b1 && n < 50);
    chk("run_rst_hold", n, RST_HOLD + 1);
    chk("run_rst_loaded", rom_loaded, 1'b1);
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_download_ctrl.md
ROM_DOWNLOAD_CTRL -- requirements
Module: rom_download_ctrl

Interface
REQ-001 SHALL have parameter INDEX, default 8'h00: ioctl_index value that selects the ROM download.
REQ-002 SHALL have parameter ROM_AW, default 16: width of the ROM write address.
REQ-003 SHALL have parameter RST_HOLD, default 16, range 1..65535: cycles core_reset stays high after a download ends.
REQ-004 SHALL have parameter WAIT_CYCLES, default 0, range 0..255: ioctl_wait stretch per accepted write.
REQ-005 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 ioctl_download  in  1  host download in progress.
REQ-008 ioctl_index  in  8  download target index.
REQ-009 ioctl_wr  in  1  one-cycle write strobe.
REQ-010 ioctl_addr  in  25  byte address.
REQ-011 ioctl_dout  in  8  write data.
REQ-012 ioctl_wait  out  1  host hold-off.
REQ-013 rom_we  out  1  ROM write enable, one cycle per accepted byte.
REQ-014 rom_addr  out  ROM_AW  registered ROM address.
REQ-015 rom_data  out  8  registered ROM data.
REQ-016 core_reset  out  1  reset to the game core.
REQ-017 rom_loaded  out  1  at least one complete download has finished.
REQ-018 byte_count  out  ROM_AW+1  accepted bytes in the current or last download.
REQ-019 addr_ovf  out  1  sticky: a write addressed beyond 2^ROM_AW.

Function
REQ-020 The block SHALL define sel = ioctl_download && (ioctl_index == INDEX).
REQ-021 The FSM SHALL have the states UNLOADED, LOADING, HOLD and RUN. Transitions:
- UNLOADED->LOADING on sel.
- LOADING->HOLD on !sel.
- HOLD->RUN when the hold counter reaches RST_HOLD-1.
- HOLD->LOADING or RUN->LOADING on sel (reload).
REQ-022 On entry to HOLD the hold counter SHALL load 0 and then increment once per cycle.
REQ-023 core_reset SHALL be registered and equal 1 in every state except RUN; it SHALL also be 1 in the cycle after any cycle with RESET high.
REQ-024 A write SHALL be accepted when ioctl_wr && sel && !ioctl_wait && ioctl_addr[24:ROM_AW]==0.
REQ-025 An accepted write SHALL produce rom_we=1 exactly one cycle later, with rom_addr=ioctl_addr[ROM_AW-1:0] and rom_data=ioctl_dout from the strobe cycle (latency 1).
REQ-026 A write with nonzero upper address bits SHALL be dropped and SHALL set addr_ovf; addr_ovf SHALL clear on entry to LOADING.
REQ-027 A write strobe arriving while ioctl_wait=1 SHALL be ignored.
REQ-028 A write strobe arriving when sel=0 SHALL be ignored.
REQ-029 With WAIT_CYCLES>0, ioctl_wait SHALL be high for exactly WAIT_CYCLES cycles starting the cycle after each accepted write.
REQ-030 With WAIT_CYCLES=0, ioctl_wait SHALL be tied to 0.
REQ-031 byte_count SHALL clear on entry to LOADING, SHALL increment on each accepted write, and SHALL saturate at 2^ROM_AW.
REQ-032 rom_loaded SHALL set on the LOADING->HOLD transition and SHALL never clear.
REQ-033 If a write is accepted in the final LOADING cycle, its rom_we SHALL still be issued.

Reset
REQ-034 RESET SHALL force: rom_we=0, ioctl_wait=0 and the wait counter to 0, and drop any pending write.
REQ-035 Under RESET the next state SHALL be LOADING if sel is high, else HOLD with the counter at 0 if rom_loaded=1, else UNLOADED.
REQ-036 RESET SHALL NOT clear rom_loaded, byte_count or addr_ovf; their power-up values SHALL be 0.
REQ-037 The power-up state SHALL be UNLOADED, with core_reset=1, rom_addr=0 and rom_data=0.

Configuration
REQ-038 With ROM_CHECKSUM_EN defined, the block SHALL add an output rom_sum[7:0]: the mod-256 sum of accepted bytes, cleared on entry to LOADING and updated in the same cycle rom_we rises.
REQ-039 Without ROM_CHECKSUM_EN, the rom_sum port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-040 Power-up, no download, 100 cycles -> core_reset=1, rom_loaded=0, rom_we never high.
REQ-041 Download with INDEX 0 of bytes 0x11,0x22,0x33 at addresses 0..2, then download falls -> three rom_we pulses, each 1 cycle after its strobe; byte_count=3; core_reset falls exactly RST_HOLD+1 cycles after ioctl_download falls; rom_loaded=1; rom_sum=0x66 when ROM_CHECKSUM_EN is defined.
REQ-042 ioctl_index=1 with writes -> no rom_we, state unchanged; write to address 0x10000 with ROM_AW=16 -> dropped, addr_ovf=1.
REQ-043 WAIT_CYCLES=3, back-to-back strobes -> ioctl_wait high for 3 cycles after the first strobe, strobes during wait ignored, byte_count=1.
REQ-044 RESET pulsed in RUN after a load -> core_reset high for RST_HOLD+1 cycles after RESET falls, rom_loaded stays 1; RESET pulsed mid-download -> pending rom_we suppressed, download resumes in LOADING.
